// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the cache-side AXI read arbiter.
package axi_read_arbiter_pkg;

    // AXI burst type encodings
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    // AXI response encodings
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Requester indices
    localparam int unsigned ICACHE_MASTER = 0;
    localparam int unsigned DCACHE_MASTER = 1;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester above last_grant, wrapping.
// Purely combinational so it can be shared by the read and write arbiters.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan upward from last_grant+1; the first hit wins.
    always_comb begin
        valid     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last_grant) + i) % N;
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between the cache refill masters.
// One burst in flight at a time; grant bits are prepended to the slave ID
// so returning beats can be checked against the current owner.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int SID_WIDTH  = ID_WIDTH + $clog2(MASTER_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // Master AR
    input  logic [MASTER_NUM-1:0]                 m_arvalid,
    output logic [MASTER_NUM-1:0]                 m_arready,
    input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_araddr,
    input  logic [MASTER_NUM-1:0][ID_WIDTH-1:0]   m_arid,
    input  logic [MASTER_NUM-1:0][7:0]            m_arlen,
    input  logic [MASTER_NUM-1:0][2:0]            m_arsize,
    input  logic [MASTER_NUM-1:0][1:0]            m_arburst,
    // Master R
    output logic [MASTER_NUM-1:0]                 m_rvalid,
    input  logic [MASTER_NUM-1:0]                 m_rready,
    output logic [DATA_WIDTH-1:0]                 m_rdata,
    output logic [ID_WIDTH-1:0]                   m_rid,
    output logic [1:0]                            m_rresp,
    output logic                                  m_rlast,
    // Slave AR
    output logic                                  s_arvalid,
    input  logic                                  s_arready,
    output logic [ADDR_WIDTH-1:0]                 s_araddr,
    output logic [SID_WIDTH-1:0]                  s_arid,
    output logic [7:0]                            s_arlen,
    output logic [2:0]                            s_arsize,
    output logic [1:0]                            s_arburst,
    // Slave R
    input  logic                                  s_rvalid,
    output logic                                  s_rready,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,
    input  logic [SID_WIDTH-1:0]                  s_rid,
    input  logic [1:0]                            s_rresp,
    input  logic                                  s_rlast,
    // Status
    output logic                                  err
);

    localparam int GW = $clog2(MASTER_NUM);

    logic [1:0]            state_q, state_d;
    logic [GW-1:0]         grant_q;
    logic [GW-1:0]         last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_q;
    logic                  err_q;

    logic                  arb_valid;
    logic [MASTER_NUM-1:0] arb_grant;
    logic [GW-1:0]         arb_idx;
    logic                  ar_take;
    logic                  ar_done;
    logic                  r_hs;
    logic                  err_set;

    rr_arbiter #(
        .N  (MASTER_NUM),
        .IW (GW)
    ) u_rr_arbiter (
        .req        (m_arvalid),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    // FSM next state and channel steering
    always_comb begin
        state_d   = state_q;
        m_arready = '0;
        s_arvalid = 1'b0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        ar_take   = 1'b0;
        ar_done   = 1'b0;
        r_hs      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    m_arready = arb_grant;
                    ar_take   = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    ar_done = 1'b1;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                r_hs              = s_rvalid & m_rready[grant_q];
                if (r_hs && s_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave AR fields come only from the latched request
    assign s_araddr  = addr_q;
    assign s_arid    = {grant_q, id_q};
    assign s_arlen   = len_q;
    assign s_arsize  = size_q;
    assign s_arburst = burst_q;

    // R payload is a zero-latency pass-through; grant bits are stripped from the ID
    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;
    assign m_rid   = s_rid[ID_WIDTH-1:0];

    // Protocol checks on the returning beats
    always_comb begin
        err_set = 1'b0;
        if (s_rvalid && (state_q != ST_R)) begin
            err_set = 1'b1;
        end
        if (s_rvalid && (state_q == ST_R) && (s_rid[SID_WIDTH-1 -: GW] != grant_q)) begin
            err_set = 1'b1;
        end
        if (r_hs && s_rlast && (beat_q != len_q)) begin
            err_set = 1'b1;
        end
        if (r_hs && !s_rlast && (beat_q == len_q)) begin
            err_set = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request so the slave sees stable fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else if (ar_take) begin
            grant_q <= arb_idx;
            addr_q  <= m_araddr[arb_idx];
            id_q    <= m_arid[arb_idx];
            len_q   <= m_arlen[arb_idx];
            size_q  <= m_arsize[arb_idx];
            burst_q <= m_arburst[arb_idx];
        end
    end

    // Round-robin pointer advances only when a burst completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GW'(MASTER_NUM - 1);
        end else if (r_hs && s_rlast) begin
            last_grant_q <= grant_q;
        end
    end

    // Beat counter for burst-length checking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q <= '0;
        end else if (ar_done) begin
            beat_q <= '0;
        end else if (r_hs) begin
            beat_q <= beat_q + 8'd1;
        end
    end

    // Sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized self-checking bench for axi_read_arbiter with a behavioural
// model of round-robin ownership, burst contents and the sticky error flag.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int MASTER_NUM = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ID_WIDTH   = 4;
    localparam int SID_WIDTH  = 5;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic [MASTER_NUM-1:0]                 m_arvalid;
    logic [MASTER_NUM-1:0]                 m_arready;
    logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_araddr;
    logic [MASTER_NUM-1:0][ID_WIDTH-1:0]   m_arid;
    logic [MASTER_NUM-1:0][7:0]            m_arlen;
    logic [MASTER_NUM-1:0][2:0]            m_arsize;
    logic [MASTER_NUM-1:0][1:0]            m_arburst;
    logic [MASTER_NUM-1:0]                 m_rvalid;
    logic [MASTER_NUM-1:0]                 m_rready;
    logic [DATA_WIDTH-1:0]                 m_rdata;
    logic [ID_WIDTH-1:0]                   m_rid;
    logic [1:0]                            m_rresp;
    logic                                  m_rlast;
    logic                                  s_arvalid;
    logic                                  s_arready;
    logic [ADDR_WIDTH-1:0]                 s_araddr;
    logic [SID_WIDTH-1:0]                  s_arid;
    logic [7:0]                            s_arlen;
    logic [2:0]                            s_arsize;
    logic [1:0]                            s_arburst;
    logic                                  s_rvalid;
    logic                                  s_rready;
    logic [DATA_WIDTH-1:0]                 s_rdata;
    logic [SID_WIDTH-1:0]                  s_rid;
    logic [1:0]                            s_rresp;
    logic                                  s_rlast;
    logic                                  err;

    always #5 clk = ~clk;

    axi_read_arbiter #(
        .MASTER_NUM (MASTER_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .SID_WIDTH  (SID_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arid    (m_arid),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rid     (m_rid),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arid    (s_arid),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rid     (s_rid),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              last_grant;
    bit              exp_err;
    logic [1:0]      pend;
    logic [31:0]     req_addr  [MASTER_NUM];
    logic [3:0]      req_id    [MASTER_NUM];
    logic [7:0]      req_len   [MASTER_NUM];
    logic [2:0]      req_size  [MASTER_NUM];
    logic [1:0]      req_burst [MASTER_NUM];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next owner: first pending master above the last one served, wrapping.
    function automatic int pick(input logic [1:0] mask, input int last);
        for (int i = 1; i <= MASTER_NUM; i++) begin
            if (mask[(last + i) % MASTER_NUM]) return (last + i) % MASTER_NUM;
        end
        return -1;
    endfunction

    task automatic post_req(input int m, input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len);
        int b;
        b = $urandom_range(0, 2);
        req_addr[m]  = addr;
        req_id[m]    = id;
        req_len[m]   = len;
        req_size[m]  = 3'($urandom_range(0, 3));
        req_burst[m] = (b == 0) ? BURST_FIXED : (b == 1) ? BURST_INCR : BURST_WRAP;
        m_araddr[m]  = addr;
        m_arid[m]    = id;
        m_arlen[m]   = len;
        m_arsize[m]  = req_size[m];
        m_arburst[m] = req_burst[m];
        m_arvalid[m] = 1'b1;
        pend[m]      = 1'b1;
    endtask

    // Assert reset with inputs as left by the caller, check outputs, then release.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_m_arready", m_arready, 0);
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_m_rvalid", m_rvalid, 0);
        check("rst_s_rready", s_rready, 0);
        check("rst_err", err, 0);
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        pend      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        last_grant = MASTER_NUM - 1;
        exp_err    = 1'b0;
    endtask

    // mode: 0 clean, 1 early rlast, 2 late rlast, 3 wrong grant bits in RID.
    // abort_at >= 0 leaves the DUT mid-burst after that many slave beats.
    task automatic serve_one(input int mode, input int abort_at, input bit stall, input int ar_dly);
        int g, dly, k, last_k, seen, stall_left, rid_g;
        bit done, slave_hs;
        logic [63:0] cur_data;
        g = pick(pend, last_grant);
        @(negedge clk);
        check("grant", m_arready, (g < 0) ? 0 : (1 << g));
        check("s_arvalid_idle", s_arvalid, 0);
        if (g < 0) return;
        @(posedge clk);
        #1;
        m_arvalid[g] = 1'b0;
        pend[g]      = 1'b0;
        dly = (ar_dly < 0) ? $urandom_range(0, 5) : ar_dly;
        for (int d = 0; d <= dly; d++) begin
            s_arready   = (d == dly);
            m_araddr[g] = $urandom();
            m_arlen[g]  = 8'($urandom());
            @(negedge clk);
            check("s_arvalid", s_arvalid, 1);
            check("s_araddr", s_araddr, req_addr[g]);
            check("s_arid", s_arid, (g << ID_WIDTH) | req_id[g]);
            check("s_arlen", s_arlen, req_len[g]);
            check("s_arsize", s_arsize, req_size[g]);
            check("s_arburst", s_arburst, req_burst[g]);
            check("m_arready_busy", m_arready, 0);
            @(posedge clk);
            #1;
        end
        s_arready = 1'b0;
        if (mode == 1) last_k = req_len[g] - 1;
        else if (mode == 2) last_k = req_len[g] + 1;
        else last_k = req_len[g];
        rid_g      = (mode == 3) ? (1 - g) : g;
        k          = 0;
        seen       = 0;
        done       = 1'b0;
        stall_left = stall ? 3 : 0;
        cur_data   = {$urandom(), $urandom()};
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (abort_at >= 0 && k == abort_at) return;
            s_rvalid = ($urandom_range(0, 3) != 0);
            s_rdata  = cur_data;
            s_rresp  = 2'($urandom());
            s_rlast  = (k == last_k);
            s_rid    = SID_WIDTH'((rid_g << ID_WIDTH) | int'(req_id[g]));
            m_rready = 2'($urandom());
            if (stall_left > 0 && k == 1) begin
                s_rvalid    = 1'b1;
                m_rready[g] = 1'b0;
                stall_left--;
            end
            @(negedge clk);
            check("m_rvalid", m_rvalid, s_rvalid ? (1 << g) : 0);
            check("s_rready", s_rready, m_rready[g]);
            if (s_rvalid) begin
                check("m_rdata", m_rdata, cur_data);
                check("m_rid", m_rid, req_id[g]);
                check("m_rresp", m_rresp, s_rresp);
                check("m_rlast", m_rlast, s_rlast);
            end
            slave_hs = s_rvalid && s_rready;
            if (m_rvalid[g] && m_rready[g]) seen++;
            @(posedge clk);
            #1;
            if (slave_hs) begin
                if (k == last_k) done = 1'b1;
                k++;
                cur_data = {$urandom(), $urandom()};
            end
        end
        if (!done) check("r_timeout", 0, 1);
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = '0;
        check("beats_to_master", seen, last_k + 1);
        last_grant = g;
        if (mode != 0) exp_err = 1'b1;
        check("err", err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        m_arvalid = '0;
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rid     = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        pend      = '0;
        do_reset();

        // Single ICache refill
        post_req(ICACHE_MASTER, 32'h8000_0040, 4'd5, 8'd3);
        serve_one(0, -1, 1'b0, -1);

        // Simultaneous pairs alternate strictly
        post_req(0, $urandom(), 4'($urandom()), 8'd1);
        post_req(1, $urandom(), 4'($urandom()), 8'd2);
        serve_one(0, -1, 1'b0, -1);
        serve_one(0, -1, 1'b0, -1);
        post_req(0, $urandom(), 4'($urandom()), 8'd0);
        post_req(1, $urandom(), 4'($urandom()), 8'd0);
        serve_one(0, -1, 1'b0, -1);
        serve_one(0, -1, 1'b0, -1);

        // Master stalls mid-burst
        post_req(DCACHE_MASTER, $urandom(), 4'($urandom()), 8'd3);
        serve_one(0, -1, 1'b1, -1);

        // Slow AR acceptance while the master changes its address
        post_req(DCACHE_MASTER, $urandom(), 4'($urandom()), 8'd2);
        serve_one(0, -1, 1'b0, 5);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            for (int m = 0; m < MASTER_NUM; m++) begin
                if (mask[m] && !pend[m]) post_req(m, $urandom(), 4'($urandom()),
                                                  8'($urandom_range(0, 7)));
            end
            serve_one(0, -1, ($urandom_range(0, 7) == 0), -1);
        end
        while (pend != 0) serve_one(0, -1, 1'b0, -1);

        // Early rlast, then a normal burst; err must stay set
        do_reset();
        post_req(0, $urandom(), 4'($urandom()), 8'd3);
        serve_one(1, -1, 1'b0, -1);
        post_req(1, $urandom(), 4'($urandom()), 8'd2);
        serve_one(0, -1, 1'b0, -1);

        // Late rlast
        do_reset();
        post_req(0, $urandom(), 4'($urandom()), 8'd4);
        serve_one(2, -1, 1'b0, -1);

        // Wrong grant bits in RID
        do_reset();
        post_req(1, $urandom(), 4'($urandom()), 8'd2);
        serve_one(3, -1, 1'b0, -1);

        // Stray R beat while idle
        do_reset();
        s_rvalid = 1'b1;
        @(negedge clk);
        check("stray_m_rvalid", m_rvalid, 0);
        @(posedge clk);
        #1;
        s_rvalid = 1'b0;
        check("stray_err", err, 1);

        // Reset in the middle of a DCache burst
        post_req(0, $urandom(), 4'($urandom()), 8'd1);
        post_req(1, $urandom(), 4'($urandom()), 8'd5);
        exp_err = 1'b1;
        serve_one(0, -1, 1'b0, -1);
        serve_one(0, 2, 1'b0, -1);
        s_rvalid = 1'b1;
        s_rlast  = 1'b0;
        m_rready = '1;
        #1;
        check("pre_rst_m_rvalid", m_rvalid, 2);
        do_reset();
        post_req(0, $urandom(), 4'($urandom()), 8'd1);
        post_req(1, $urandom(), 4'($urandom()), 8'd1);
        serve_one(0, -1, 1'b0, -1);
        serve_one(0, -1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read channel (AR + R) between MASTER_NUM cache requesters: master 0 = ICache refill, master 1 = DCache refill.
- Sits between the cache miss handlers and the bus bridge.
- Round-robin grant, one outstanding burst at a time.
- Routes R beats back to the granted master and checks burst integrity.

Parameters:
- MASTER_NUM, 2, number of requesters.
- ADDR_WIDTH, 32, physical address width.
- DATA_WIDTH, 64, R data width.
- ID_WIDTH, 4, master-side ARID/RID width.
- SID_WIDTH, ID_WIDTH+$clog2(MASTER_NUM), slave-side ID width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- m_arvalid  input  MASTER_NUM  per-master AR valid
- m_arready  output  MASTER_NUM  per-master AR ready
- m_araddr  input  MASTER_NUM x ADDR_WIDTH  AR address
- m_arid  input  MASTER_NUM x ID_WIDTH  AR id
- m_arlen  input  MASTER_NUM x 8  burst length minus 1
- m_arsize  input  MASTER_NUM x 3  beat size
- m_arburst  input  MASTER_NUM x 2  burst type
- m_rvalid  output  MASTER_NUM  per-master R valid
- m_rready  input  MASTER_NUM  per-master R ready
- m_rdata  output  DATA_WIDTH  R data, shared by all masters
- m_rid  output  ID_WIDTH  R id with the grant bits stripped
- m_rresp  output  2  R response
- m_rlast  output  1  R last
- s_arvalid / s_arready  output / input  1  slave AR handshake
- s_araddr, s_arid, s_arlen, s_arsize, s_arburst  output  ADDR_WIDTH, SID_WIDTH, 8, 3, 2  slave AR fields
- s_rvalid / s_rready  input / output  1  slave R handshake
- s_rdata, s_rid, s_rresp, s_rlast  input  DATA_WIDTH, SID_WIDTH, 2, 1  slave R fields
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, async): state=IDLE; all valid/ready outputs 0; err=0; beat counter 0; last_grant=MASTER_NUM-1, so master 0 wins first.
- FSM states: IDLE, AR, R.
- IDLE:
  - If any m_arvalid is set, grant the first requester searching upward from last_grant+1, wrapping modulo MASTER_NUM.
  - Assert m_arready[grant] combinationally in the same cycle.
  - Latch addr, len, size, burst and id into registers; go to AR.
  - m_arready is 0 in all other states.
- AR:
  - s_arvalid=1, driven from the latched registers.
  - s_arid = {grant, latched id}.
  - Fields stay stable until s_arready.
  - On s_arvalid & s_arready: go to R, clear the beat counter.
- R:
  - m_rvalid[grant] = s_rvalid; all other m_rvalid bits 0.
  - s_rready = m_rready[grant].
  - m_rdata, m_rresp, m_rlast pass through combinationally. m_rid = s_rid[ID_WIDTH-1:0].
  - On each handshake, increment the beat counter.
  - On a handshake with s_rlast=1: last_grant<=grant; go to IDLE.
  - Minimum turnaround: no new grant in the cycle rlast is accepted; the next grant is on the following cycle.
- Latency: request accepted in cycle N, s_arvalid in cycle N+1. R path has zero added latency.
- err (sticky until reset) is set on any of:
  - s_rlast at beat count != latched len;
  - beat count reaching len without s_rlast;
  - s_rid grant bits != grant;
  - s_rvalid while not in state R.
  The burst still completes on s_rlast regardless of err.
- Simultaneous requests: exactly one grant per IDLE cycle. A lone requester is granted every time with no penalty.
- Beat counter is 8 bits; no wrap within a legal burst (len ≤ 255).
- A master must hold m_arvalid until m_arready. Dropping m_arvalid before grant is legal and no grant occurs for it.
- Reset mid-burst: state returns to IDLE immediately. The slave is required to be reset concurrently.

Decomposition:
- Shared package: AXI burst encodings (FIXED/INCR/WRAP), RESP encodings, master index constants ICACHE_MASTER=0, DCACHE_MASTER=1.
- One sub-module: rr_arbiter (request vector + last_grant -> one-hot grant and index), reusable by the write-side arbiter.

Test Plan:
- Single master 0: araddr=0x8000_0040, arlen=3, id=5 → s_arid={0,5}; 4 beats forwarded to master 0; m_rid=5; back in IDLE after rlast; err=0.
- Both masters request in the same IDLE cycle after reset → master 0 granted first, master 1 next; a third simultaneous pair after that → master 0 again (strict alternation).
- m_rready[grant] held low for 3 cycles mid-burst → s_rready=0 for those cycles; no beat lost or duplicated; beat count ends at 4.
- Slave asserts rlast on beat 2 of arlen=3 → err=1 and stays 1; FSM returns to IDLE; next request is served normally.
- s_arready delayed 5 cycles while master 1 changes m_araddr → s_araddr stays at the latched value throughout.
- rst asserted in state R mid-burst → all outputs 0 asynchronously; after release master 0 has priority; err=0.
